// File: rtl/eprisc_io_master_pkg.sv
// rtl/eprisc_io_master_pkg.sv - shared encodings for the epRISC peripheral bus initiator
package eprisc_io_master_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] REG_DIR   = 2'd0;
  localparam logic [1:0] REG_INT   = 2'd1;
  localparam logic [1:0] REG_VALUE = 2'd2;

endpackage

// File: rtl/eprisc_io_int_agg.sv
// rtl/eprisc_io_int_agg.sv - sticky per-slot interrupt pending bits with lowest-index priority
module eprisc_io_int_agg #(
  parameter int NUM_DEV  = 4,
  parameter int DEV_BITS = 2
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic [NUM_DEV-1:0]  iInterrupt,
  input  logic [NUM_DEV-1:0]  iClear,
  output logic                oInterrupt,
  output logic [DEV_BITS-1:0] oIntDevice
);

  logic [NUM_DEV-1:0]  pending_q, pending_d;
  logic                irq_q;
  logic [DEV_BITS-1:0] idx_q, idx_d;

  // New requests are OR-ed in after the clear so a same-edge set wins.
  assign pending_d = (pending_q & ~iClear) | iInterrupt;

  always_comb begin
    idx_d = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (pending_q[i]) idx_d = i[DEV_BITS-1:0];
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= |pending_q;
      idx_q     <= idx_d;
    end
  end

  assign oInterrupt = irq_q;
  assign oIntDevice = idx_q;

endmodule

// File: rtl/eprisc_io_master.sv
// rtl/eprisc_io_master.sv - epRISC peripheral bus initiator with one-hot enables
// Optional interrupt aggregation enabled by IO_MASTER_INTERRUPT_EN.
module eprisc_io_master
  import eprisc_io_master_pkg::*;
#(
  parameter int NUM_DEV     = 4,
  parameter int DEV_BITS    = 2,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iRequest,
  input  logic                iReqWrite,
  input  logic [DEV_BITS-1:0] iReqDevice,
  input  logic [1:0]          iReqAddress,
  input  logic [BUS_W-1:0]    iReqData,
  output logic                oBusy,
  output logic                oDone,
  output logic                oError,
  output logic [BUS_W-1:0]    oRdData,
  output logic [1:0]          oAddress,
  output logic [BUS_W-1:0]    oData,
  input  logic [BUS_W-1:0]    iData,
  output logic                oWrite,
  output logic [NUM_DEV-1:0]  oEnable,
  input  logic [NUM_DEV-1:0]  iInterrupt,
  output logic                oInterrupt,
  output logic [DEV_BITS-1:0] oIntDevice
);

  localparam logic [DEV_BITS:0] NUM_DEV_L = (DEV_BITS + 1)'(NUM_DEV);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [DEV_BITS-1:0] dev_q, dev_d;
  logic [1:0]          addr_q, addr_d;
  logic [BUS_W-1:0]    data_q, data_d;
  logic [BUS_W-1:0]    rdata_q, rdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                dev_ok;
  logic [NUM_DEV-1:0]  dev_hot;

  assign dev_ok = {1'b0, dev_q} < NUM_DEV_L;

  always_comb begin
    dev_hot = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      dev_hot[i] = dev_ok && (dev_q == i[DEV_BITS-1:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    dev_d   = dev_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iRequest) begin
          write_d = iReqWrite;
          dev_d   = iReqDevice;
          addr_d  = iReqAddress;
          data_d  = iReqData;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = WAIT_CYCLES[3:0];
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Unmapped slots read back as zero rather than floating bus data.
          if (!write_q) rdata_d = dev_ok ? iData : '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      dev_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      dev_q   <= dev_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oBusy    = (state_q != ST_IDLE);
  assign oDone    = (state_q == ST_DONE);
  assign oError   = oDone && !dev_ok;
  assign oWrite   = oBusy && write_q;
  assign oData    = data_q;
  assign oAddress = addr_q;
  assign oRdData  = rdata_q;
  assign oEnable  = (state_q == ST_STROBE) ? dev_hot : '0;

`ifdef IO_MASTER_INTERRUPT_EN
  logic [NUM_DEV-1:0] int_clear;

  // Reading a slot's interrupt register acknowledges its pending bit.
  assign int_clear = (oDone && !write_q && addr_q == REG_INT) ? dev_hot : '0;

  eprisc_io_int_agg #(
    .NUM_DEV  (NUM_DEV),
    .DEV_BITS (DEV_BITS)
  ) u_int_agg (
    .iClock     (iClock),
    .iReset     (iReset),
    .iInterrupt (iInterrupt),
    .iClear     (int_clear),
    .oInterrupt (oInterrupt),
    .oIntDevice (oIntDevice)
  );
`else
  logic unused_int;
  assign unused_int = ^iInterrupt;
  assign oInterrupt = 1'b0;
  assign oIntDevice = '0;
`endif

endmodule

// File: tb/tb_eprisc_io_master.sv
// tb/tb_eprisc_io_master.sv - randomized self-checking bench for eprisc_io_master
module tb_eprisc_io_master;

  localparam int N  = 3;
  localparam int DB = 2;
  localparam int W  = 2;

  logic          iClock = 1'b0;
  logic          iReset = 1'b1;
  logic          iRequest = 1'b0;
  logic          iReqWrite = 1'b0;
  logic [DB-1:0] iReqDevice = '0;
  logic [1:0]    iReqAddress = '0;
  logic [15:0]   iReqData = '0;
  logic          oBusy, oDone, oError, oWrite, oInterrupt;
  logic [15:0]   oRdData, oData;
  logic [15:0]   iData = '0;
  logic [1:0]    oAddress;
  logic [N-1:0]  oEnable;
  logic [N-1:0]  iInterrupt = '0;
  logic [DB-1:0] oIntDevice;

  eprisc_io_master #(.NUM_DEV(N), .DEV_BITS(DB), .WAIT_CYCLES(W)) dut (
    .iClock(iClock), .iReset(iReset), .iRequest(iRequest), .iReqWrite(iReqWrite),
    .iReqDevice(iReqDevice), .iReqAddress(iReqAddress), .iReqData(iReqData),
    .oBusy(oBusy), .oDone(oDone), .oError(oError), .oRdData(oRdData),
    .oAddress(oAddress), .oData(oData), .iData(iData), .oWrite(oWrite),
    .oEnable(oEnable), .iInterrupt(iInterrupt), .oInterrupt(oInterrupt),
    .oIntDevice(oIntDevice)
  );

  always #5 iClock = ~iClock;

  int n_cmp = 0;
  int n_bad = 0;

  logic          rand_int = 1'b0;
  logic [N-1:0]  int_hold = '0;
  logic [N-1:0]  model_clr = '0;
  logic [N-1:0]  pend_m = '0;
  logic          exp_irq = 1'b0;
  logic [DB-1:0] exp_idev = '0;
  logic [15:0]   exp_rd = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Interrupt reference: sticky pending set, read-acknowledge, one-cycle-late report.
  always @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      pend_m   <= '0;
      exp_irq  <= 1'b0;
      exp_idev <= '0;
    end else begin
`ifdef IO_MASTER_INTERRUPT_EN
      exp_irq  <= |pend_m;
      exp_idev <= DB'(lowest(pend_m));
      pend_m   <= (pend_m & ~model_clr) | iInterrupt;
`endif
    end
  end

  task automatic next_cycle();
    @(negedge iClock);
    if (rand_int) iInterrupt = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
    else iInterrupt = int_hold;
    check("irq", oInterrupt, exp_irq);
    check("idev", oIntDevice, exp_idev);
  endtask

  task automatic txn(input logic w, input logic [DB-1:0] dev, input logic [1:0] addr,
                     input logic [15:0] data, input logic [15:0] rdv);
    logic         ok;
    logic [N-1:0] hot;
    ok  = (int'(dev) < N);
    hot = ok ? (N'(1) << dev) : '0;
    iReqWrite = w; iReqDevice = dev; iReqAddress = addr; iReqData = data;
    iRequest = 1'b1;
    next_cycle();
    iRequest = 1'b0;
    iReqWrite = 1'($urandom); iReqDevice = DB'($urandom);
    iReqAddress = 2'($urandom); iReqData = 16'($urandom);
    for (int k = 1; k <= 3 + W; k++) begin
      check("busy", oBusy, 1'b1);
      check("enable", oEnable, (k >= 2 && k <= 2 + W) ? hot : '0);
      check("done", oDone, k == 3 + W);
      check("error", oError, (k == 3 + W) && !ok);
      check("write", oWrite, w);
      check("data", oData, data);
      check("addr", oAddress, addr);
      if (k == 3 + W) check("rddata", oRdData, exp_rd);
      if (k >= 2 && k <= 2 + W) iData = (k == 2 + W) ? rdv : 16'($urandom);
      if (k == 2 + W && !w) exp_rd = ok ? rdv : 16'h0000;
      model_clr = (k == 3 + W && !w && addr == 2'd1 && ok) ? hot : '0;
      next_cycle();
    end
    model_clr = '0;
    check("idle_busy", oBusy, 1'b0);
    check("idle_done", oDone, 1'b0);
    check("idle_err", oError, 1'b0);
    check("idle_write", oWrite, 1'b0);
    check("idle_en", oEnable, '0);
    check("idle_data", oData, data);
    check("idle_rd", oRdData, exp_rd);
  endtask

  initial begin
    next_cycle();
    next_cycle();
    check("rst_busy", oBusy, 1'b0);
    check("rst_done", oDone, 1'b0);
    check("rst_err", oError, 1'b0);
    check("rst_rd", oRdData, 16'h0);
    check("rst_data", oData, 16'h0);
    check("rst_addr", oAddress, 2'd0);
    check("rst_en", oEnable, '0);
    check("rst_write", oWrite, 1'b0);
    iReset = 1'b0;
    next_cycle();

    txn(1'b1, 2'd1, 2'd0, 16'h00F0, 16'h0);
    txn(1'b0, 2'd2, 2'd2, 16'h1234, 16'hA5C3);
    check("rd_a5c3", oRdData, 16'hA5C3);
    txn(1'b0, 2'd3, 2'd0, 16'h5555, 16'hBEEF);
    check("oor_rd", oRdData, 16'h0000);

    rand_int = 1'b1;
    for (int t = 0; t < 150; t++) begin
      txn(1'($urandom), DB'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) == 0) next_cycle();
    end
    rand_int = 1'b0;
    int_hold = '0;

    // Abort a read while its enable is active.
    iReqWrite = 1'b0; iReqDevice = 2'd1; iReqAddress = 2'd2; iReqData = 16'h7777;
    iRequest = 1'b1;
    next_cycle();
    iRequest = 1'b0;
    next_cycle();
    check("pre_rst_en", oEnable, 3'b010);
    #2 iReset = 1'b1;
    #1;
    check("rst_mid_en", oEnable, '0);
    check("rst_mid_busy", oBusy, 1'b0);
    check("rst_mid_done", oDone, 1'b0);
    exp_rd = 16'h0;
    model_clr = '0;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      check("rst_hold_done", oDone, 1'b0);
      check("rst_hold_busy", oBusy, 1'b0);
    end
    iReset = 1'b0;
    next_cycle();
    txn(1'b0, 2'd0, 2'd3, 16'h0F0F, 16'h3C3C);
    check("post_rst_rd", oRdData, 16'h3C3C);

    int_hold = 3'b100;
    next_cycle();
    int_hold = 3'b010;
    next_cycle();
    int_hold = 3'b000;
    next_cycle();
    next_cycle();
`ifdef IO_MASTER_INTERRUPT_EN
    check("int_a_irq", oInterrupt, 1'b1);
    check("int_a_dev", oIntDevice, 2'd1);
    txn(1'b0, 2'd1, 2'd1, 16'h0, 16'h0002);
    next_cycle();
    check("int_b_irq", oInterrupt, 1'b1);
    check("int_b_dev", oIntDevice, 2'd2);
    int_hold = 3'b100;
    txn(1'b0, 2'd2, 2'd1, 16'h0, 16'h0004);
    int_hold = 3'b000;
    next_cycle();
    next_cycle();
    check("int_c_irq", oInterrupt, 1'b1);
    check("int_c_dev", oIntDevice, 2'd2);
`else
    check("noint_irq", oInterrupt, 1'b0);
    check("noint_dev", oIntDevice, 2'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
